// File: rtl/router_fsm.sv
// router_fsm: ingress control FSM for the 1x3 router.
// Sequences header decode, first-data load, payload load, full-FIFO stall,
// parity load and parity check, and back-pressures the source via busy.
// Optional build macro: ROUTER_FSM_DROP_EN adds a DROP_PACKET state that
// discards packets whose header address is 3.
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              busy,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    WAIT_TILL_EMPTY    = 4'd1,
    LOAD_FIRST_DATA    = 4'd2,
    LOAD_DATA          = 4'd3,
    FIFO_FULL_STATE    = 4'd4,
    LOAD_AFTER_FULL    = 4'd5,
    LOAD_PARITY        = 4'd6,
    CHECK_PARITY_ERROR = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Per-FIFO status selected by the incoming header and by the latched address.
  logic hdr_valid;
  logic hdr_empty;
  logic addr_empty;
  logic addr_soft_reset;
  logic soft_reset_allowed;

  // Select FIFO empty / soft-reset flags for the header byte and the latched address.
  always_comb begin
    hdr_valid       = (data_in <= ADDR_W'(2));
    hdr_empty       = 1'b0;
    addr_empty      = 1'b0;
    addr_soft_reset = 1'b0;
    case (data_in)
      ADDR_W'(0): hdr_empty = fifo_empty_0;
      ADDR_W'(1): hdr_empty = fifo_empty_1;
      ADDR_W'(2): hdr_empty = fifo_empty_2;
      default:    hdr_empty = 1'b0;
    endcase
    // addr_q can only hold 3 while discarding a packet, where soft resets
    // are ignored anyway, so the default arm never matters.
    case (addr_q)
      ADDR_W'(1): begin
        addr_empty      = fifo_empty_1;
        addr_soft_reset = soft_reset_1;
      end
      ADDR_W'(2): begin
        addr_empty      = fifo_empty_2;
        addr_soft_reset = soft_reset_2;
      end
      default: begin
        addr_empty      = fifo_empty_0;
        addr_soft_reset = soft_reset_0;
      end
    endcase
  end

  // State and latched destination address registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    busy          = 1'b1;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;

    // Header address is re-captured on every valid byte while decoding.
    if ((state_q == DECODE_ADDRESS) && pkt_valid) begin
      addr_d = data_in;
    end

    case (state_q)
      DECODE_ADDRESS: begin
        busy       = 1'b0;
        detect_add = 1'b1;
        if (pkt_valid) begin
          if (hdr_valid) begin
            state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
`ifdef ROUTER_FSM_DROP_EN
          else begin
            state_d = DROP_PACKET;
          end
`endif
        end
      end
      WAIT_TILL_EMPTY: begin
        if (addr_empty) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: begin
        busy          = 1'b0;
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        // A full FIFO must stall before the source's pkt_valid drop is honoured.
        if (fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
        if (!fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
        if (parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
        state_d       = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
        state_d     = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
`ifdef ROUTER_FSM_DROP_EN
      DROP_PACKET: begin
        busy = 1'b0;
        if (!pkt_valid) begin
          state_d = DECODE_ADDRESS;
        end
      end
`endif
      default: begin
        state_d = DECODE_ADDRESS;
      end
    endcase

    // A read-timeout on the addressed FIFO abandons the packet in flight.
    soft_reset_allowed = (state_q != DECODE_ADDRESS);
`ifdef ROUTER_FSM_DROP_EN
    if (state_q == DROP_PACKET) begin
      soft_reset_allowed = 1'b0;
    end
`endif
    if (soft_reset_allowed && addr_soft_reset) begin
      state_d = DECODE_ADDRESS;
    end
  end

endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed test-plan sequences followed by random stimulus,
// every cycle compared against a phase-level behavioural model.
module tb_router_fsm;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn, pkt_valid, fifo_full;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       busy, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, write_enb_reg, rst_int_reg;

  router_fsm #(.ADDR_W(2)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg)
  );

  // Bit order: busy, detect_add, lfd, ld, laf, full, write_enb, rst_int
  logic [7:0] dut_out;
  assign dut_out = {busy, detect_add, lfd_state, ld_state, laf_state,
                    full_state, write_enb_reg, rst_int_reg};

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int check_cnt = 0;
  int cnt [8];

  // Model: the packet phase the ingress path is in, plus the latched address.
  string      ph    = "IDLE";
  logic [1:0] maddr = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_out(input string p);
    logic b;
    b = !(p == "IDLE" || p == "LD" || p == "DROP");
    return {b, p == "IDLE", p == "LFD", p == "LD", p == "LAF", p == "FULL",
            (p == "LD" || p == "PAR" || p == "LAF"), p == "CHK"};
  endfunction

  task automatic model_step();
    logic [3:0] emp;
    logic [3:0] srs;
    logic [1:0] a;
    string      nx;
    emp = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srs = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    a   = (maddr == 2'd3) ? 2'd0 : maddr;
    nx  = ph;
    if (!resetn) begin
      ph    = "IDLE";
      maddr = 2'd0;
      return;
    end
    if (ph == "IDLE") begin
      if (pkt_valid) begin
        if (data_in != 2'd3) begin
          nx = emp[data_in] ? "LFD" : "WAIT";
        end else begin
`ifdef ROUTER_FSM_DROP_EN
          nx = "DROP";
`else
          nx = "IDLE";
`endif
        end
        maddr = data_in;
      end
    end else if (ph == "DROP") begin
      nx = pkt_valid ? "DROP" : "IDLE";
    end else if (srs[a]) begin
      nx = "IDLE";
    end else if (ph == "WAIT") begin
      nx = emp[a] ? "LFD" : "WAIT";
    end else if (ph == "LFD") begin
      nx = "LD";
    end else if (ph == "LD") begin
      nx = fifo_full ? "FULL" : (!pkt_valid ? "PAR" : "LD");
    end else if (ph == "FULL") begin
      nx = fifo_full ? "FULL" : "LAF";
    end else if (ph == "LAF") begin
      nx = parity_done ? "IDLE" : (low_pkt_valid ? "PAR" : "LD");
    end else if (ph == "PAR") begin
      nx = "CHK";
    end else if (ph == "CHK") begin
      nx = fifo_full ? "FULL" : "IDLE";
    end
    ph = nx;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 8; i++) cnt[i] = 0;
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check(tag, {24'd0, dut_out}, {24'd0, exp_out(ph)});
    for (int i = 0; i < 8; i++) cnt[i] += int'(dut_out[i]);
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();

    // Reset for two cycles
    resetn = 1'b0;
    tick("reset0");
    tick("reset1");
    check("reset_outputs", {24'd0, dut_out}, 32'h40);
    resetn = 1'b1;
    tick("idle");

    // Packet to FIFO 1: header, 3 payload bytes, parity
    clr_cnt();
    pkt_valid = 1'b1; data_in = 2'd1;
    tick("p1_hdr");
    tick("p1_lfd");
    tick("p1_ld1");
    tick("p1_ld2");
    pkt_valid = 1'b0;
    tick("p1_par");
    tick("p1_chk");
    tick("p1_dec");
    check("p1_lfd_cycles", cnt[5], 1);
    check("p1_ld_cycles",  cnt[4], 3);
    check("p1_wen_cycles", cnt[1], 4);
    check("p1_rst_cycles", cnt[0], 1);
    check("p1_back_decode", {31'd0, detect_add}, 1);

    // Header to FIFO 2 while it is not empty for 4 cycles
    fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
    clr_cnt();
    tick("w_hdr");
    pkt_valid = 1'b0;
    tick("w_1");
    tick("w_2");
    tick("w_3");
    check("w_busy_cycles", cnt[7], 4);
    check("w_wen_cycles",  cnt[1], 0);
    fifo_empty_2 = 1'b1;
    tick("w_lfd");
    check("w_lfd_after_empty", {31'd0, lfd_state}, 1);
    tick("w_ld");
    tick("w_par");
    tick("w_chk");
    tick("w_dec");

    // FIFO full mid-payload for 3 cycles, low_pkt_valid on release
    pkt_valid = 1'b1; data_in = 2'd0;
    tick("f_hdr");
    tick("f_lfd");
    clr_cnt();
    fifo_full = 1'b1;
    tick("f_full1");
    tick("f_full2");
    tick("f_full3");
    fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    tick("f_laf");
    tick("f_par");
    low_pkt_valid = 1'b0;
    tick("f_chk");
    tick("f_dec");
    check("f_full_cycles", cnt[2], 3);
    check("f_laf_cycles",  cnt[3], 1);
    check("f_rst_cycles",  cnt[0], 1);

    // Soft reset while waiting on FIFO 0
    fifo_empty_0 = 1'b0; pkt_valid = 1'b1; data_in = 2'd0;
    tick("s_hdr");
    pkt_valid = 1'b0; soft_reset_1 = 1'b1;
    tick("s_other_sr");
    check("s_other_ignored_busy", {31'd0, busy}, 1);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    tick("s_own_sr");
    check("s_own_detect", {31'd0, detect_add}, 1);
    check("s_own_busy", {31'd0, busy}, 0);
    soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
    tick("s_idle");

    // Header address 3 with pkt_valid held for 4 cycles
    clr_cnt();
    pkt_valid = 1'b1; data_in = 2'd3;
    tick("d_1");
    tick("d_2");
    tick("d_3");
    tick("d_4");
    pkt_valid = 1'b0;
    tick("d_end");
    check("d_wen_cycles",  cnt[1], 0);
    check("d_busy_cycles", cnt[7], 0);
    check("d_strobes", cnt[5] + cnt[4] + cnt[3] + cnt[2] + cnt[0], 0);
    check("d_final_detect", {31'd0, detect_add}, 1);
`ifdef ROUTER_FSM_DROP_EN
    check("d_detect_cycles", cnt[6], 1);
`else
    check("d_detect_cycles", cnt[6], 5);
`endif

    // Random stimulus against the model
    for (int n = 0; n < 3000; n++) begin
      resetn        = ($urandom_range(0, 99) != 0);
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 39) == 0);
      soft_reset_1  = ($urandom_range(0, 39) == 0);
      soft_reset_2  = ($urandom_range(0, 39) == 0);
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
